dm_access: RTL
==============

// Module: dm_access
// PURPOSE
//  Data-memory access stage downstream of the instruction decoder: consumes MemWrite/DMType plus ALU address and rs2 data.
//  Runs one load/store per request over a req/ack memory bus and returns a lane-aligned, sign/zero-extended load result.
//  Builds byte enables, replicates store data across lanes, and guards the bus with a timeout counter.
// PARAMETERS
//  AW           32  byte-address width
//  TIMEOUT_CYC  16  max cycles in BUS without bus_ack before an error response (>=2)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rstn         in   1   reset, synchronous, active-low
//  req_valid    in   1   access request from MEM stage
//  req_ready    out  1   high only in IDLE; request accepted when req_valid&req_ready at clk edge
//  req_we       in   1   1=store (MemWrite), 0=load
//  req_dmtype   in   3   000 word,001 half,010 half-u,011 byte,100 byte-u; 101-111 treated as word
//  req_addr     in   AW  byte address
//  req_wdata    in   32  store data, LSB-justified
//  rsp_valid    out  1   one-cycle completion pulse (loads and stores)
//  rsp_rdata    out  32  extended load data; 0 for stores and errors
//  rsp_err      out  1   valid with rsp_valid: timeout or misalign trap
//  rsp_misalign out  1   valid with rsp_valid: misaligned access trapped (0 when macro absent)
//  bus_req      out  1   held high until bus_ack
//  bus_we       out  1   write strobe, stable while bus_req
//  bus_addr     out  AW  word-aligned address ({req_addr[AW-1:2],2'b00})
//  bus_be       out  4   byte lane enables
//  bus_wdata    out  32  lane-replicated store data
//  bus_ack      in   1   slave completion; ignored unless state==BUS
//  bus_rdata    in   32  read word, valid when bus_ack
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; state IDLE, timeout counter 0. Reset in any state aborts:
//   bus_req drops at the reset edge, no rsp_valid is produced for the aborted access.
//  FSM IDLE->BUS on accept; BUS->RESP on bus_ack or timeout; RESP->IDLE unconditionally (rsp_valid=1 in RESP only).
//  All bus_* and rsp_* outputs are registered. Request fields are captured at accept; inputs may change afterwards.
//  Latency: accept at edge T -> bus_req high T+1; ack sampled at edge A -> rsp_valid high cycle A+1; minimum 3 cycles.
//  Back-to-back: the next request is accepted no earlier than the edge that leaves RESP.
//  Byte enables: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0].
//  Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as-is.
//  Load: sh = bus_rdata >> (8*addr[1:0]); byte/half sign-extend unless the -u variant; word uses the full bus_rdata.
//  Timeout: counter clears on entering BUS and increments each BUS cycle without bus_ack.
//   At count==TIMEOUT_CYC-1 with no ack -> RESP with rsp_err=1, rsp_rdata=0, bus_req dropped.
//   An ack in the same cycle as the timeout wins (normal response).
//  Without the macro, misaligned accesses are not trapped: word ignores addr[1:0]; half ignores addr[0].
// CONFIGURATION
//  DM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no bus access.
//   Such an access goes IDLE->RESP directly: rsp_valid=1, rsp_err=1, rsp_misalign=1, rsp_rdata=0, latency 1 cycle.
//  DM_MISALIGN_TRAP_EN undefined: rsp_misalign tied 0; behaviour as above.
// STRUCTURE
//  Package dm_pkg: DMType codes (DM_WORD..DM_BYTE_U), state encoding (ST_IDLE/ST_BUS/ST_RESP), BE constants.
//  Sub-module dm_lane_align (combinational): dmtype+addr[1:0]+wdata -> be/wdata; dmtype+addr[1:0]+rdata -> extended load.
//  dm_access holds the FSM, capture registers and timeout counter.
// TESTING
//  1 sw addr=0x104 wdata=0xDEADBEEF, ack 2 cycles after bus_req -> bus_be=1111, bus_addr=0x104, bus_wdata=0xDEADBEEF, rsp_valid once, rsp_rdata=0.
//  2 lb addr=0x103, bus_rdata=0x80FF_0000 -> bus_be=1000, rsp_rdata=0xFFFFFF80; lbu same -> 0x00000080.
//  3 sh addr=0x22 wdata=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD; lhu addr=0x22, rdata=0xBEEF0000 -> 0x0000BEEF.
//  4 lw with bus_ack never asserted, TIMEOUT_CYC=16 -> bus_req high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  5 macro on: lw addr=0x101 -> no bus_req, rsp_valid next cycle, rsp_err=1, rsp_misalign=1; macro off -> bus_addr=0x100, be=1111.
//  6 rstn low during BUS -> bus_req=0 after that edge, no rsp_valid, req_ready=1; new sb addr=0x3 then gives be=1000.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types for the data-memory access stage: DMType codes, FSM states, byte-enable constants.
package dm_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dmtype_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Codes 101-111 fall through to word.
  function automatic size_e dm_size(input logic [2:0] t);
    case (t)
      DM_HALF, DM_HALF_U: return SZ_HALF;
      DM_BYTE, DM_BYTE_U: return SZ_BYTE;
      default:            return SZ_WORD;
    endcase
  endfunction

  function automatic logic dm_unsigned(input logic [2:0] t);
    return (t == DM_HALF_U) || (t == DM_BYTE_U);
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: store byte enables / replicated data, and load extraction with extension.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  st_dmtype,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_dmtype,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    st_be   = BE_WORD;
    st_data = st_wdata;
    case (dm_size(st_dmtype))
      SZ_HALF: begin
        st_be   = st_off[1] ? BE_HALF_HI : BE_HALF_LO;
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_BYTE: begin
        st_be   = BE_BYTE0 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Half ignores addr[0]; byte picks the lane addressed by addr[1:0].
  always_comb begin
    half_sel = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    byte_sel = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_data  = ld_rdata;
    case (dm_size(ld_dmtype))
      SZ_HALF: ld_data = dm_unsigned(ld_dmtype) ? {16'h0000, half_sel}
                                                 : {{16{half_sel[15]}}, half_sel};
      SZ_BYTE: ld_data = dm_unsigned(ld_dmtype) ? {24'h000000, byte_sel}
                                                 : {{24{byte_sel[7]}}, byte_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access.sv
// Data-memory access stage: one load/store per request over a req/ack bus with timeout.
// Optional misaligned-access trap enabled by defining DM_MISALIGN_TRAP_EN.
module dm_access #(
  parameter int unsigned AW          = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_dmtype,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_misalign,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
);
  import dm_pkg::*;

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);

  state_e        state, next_state;
  logic [CW-1:0] cnt;
  logic          timeout;
  logic          accept;
  logic          mis_req;

  logic          cap_we;
  logic [2:0]    cap_dmtype;
  logic [1:0]    cap_off;

  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic [31:0]   ld_data;

  logic          bus_req_n;
  logic          rsp_valid_n;
  logic          rsp_err_n;
  logic [31:0]   rsp_rdata_n;

  dm_lane_align u_align (
    .st_dmtype (req_dmtype),
    .st_off    (req_addr[1:0]),
    .st_wdata  (req_wdata),
    .st_be     (st_be),
    .st_data   (st_data),
    .ld_dmtype (cap_dmtype),
    .ld_off    (cap_off),
    .ld_rdata  (bus_rdata),
    .ld_data   (ld_data)
  );

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && (state == ST_IDLE);
  assign timeout   = (cnt == CW'(TIMEOUT_CYC - 1));

`ifdef DM_MISALIGN_TRAP_EN
  logic rsp_mis_n;
  always_comb begin
    case (dm_size(req_dmtype))
      SZ_HALF: mis_req = req_addr[0];
      SZ_WORD: mis_req = (req_addr[1:0] != 2'b00);
      default: mis_req = 1'b0;
    endcase
  end
`else
  assign mis_req = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = mis_req ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_ack || timeout) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; an ack in the timeout cycle takes priority.
  always_comb begin
    bus_req_n   = (next_state == ST_BUS);
    rsp_valid_n = (next_state == ST_RESP);
    rsp_err_n   = 1'b0;
    rsp_rdata_n = '0;
`ifdef DM_MISALIGN_TRAP_EN
    rsp_mis_n   = 1'b0;
`endif
    if (state == ST_BUS && next_state == ST_RESP) begin
      if (bus_ack) rsp_rdata_n = cap_we ? '0 : ld_data;
      else         rsp_err_n   = 1'b1;
    end
    if (state == ST_IDLE && next_state == ST_RESP) begin
      rsp_err_n = 1'b1;
`ifdef DM_MISALIGN_TRAP_EN
      rsp_mis_n = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_dmtype <= '0;
      cap_off    <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state     <= next_state;
      bus_req   <= bus_req_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
      if (accept && !mis_req) begin
        cap_we     <= req_we;
        cap_dmtype <= req_dmtype;
        cap_off    <= req_addr[1:0];
        bus_we     <= req_we;
        bus_addr   <= {req_addr[AW-1:2], 2'b00};
        bus_be     <= st_be;
        bus_wdata  <= st_data;
        cnt        <= '0;
      end else if (state == ST_BUS && !bus_ack && !timeout) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rstn) rsp_misalign <= 1'b0;
    else       rsp_misalign <= rsp_mis_n;
  end
`else
  assign rsp_misalign = 1'b0;
`endif

endmodule
